// File: rtl/alif_array.sv
// alif_array: time-multiplexed array of adaptive leaky integrate-and-fire neurons.
// Define ALIF_REFRACTORY_EN to add per-channel refractory counters.
module alif_array #(
    parameter int N_CH            = 3,
    parameter int W               = 8,
    parameter int IN_W            = 12,
    parameter int LEAK_SHIFT      = 1,
    parameter int THR_BASE        = 200,
    parameter int THR_INC         = 16,
    parameter int THR_DECAY_SHIFT = 3,
    parameter int REF_STEPS       = 2,
    localparam int SW             = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step_valid,
    output logic            step_ready,
    input  logic [IN_W-1:0] current,
    output logic [N_CH-1:0] spikes,
    output logic            done,
    input  logic [SW-1:0]   mon_sel,
    output logic [W-1:0]    mon_state,
    output logic [W-1:0]    mon_thr
);
    localparam int SWD = (W > IN_W + 1 ? W : IN_W + 1) + 1;
    localparam int RW = REF_STEPS > 0 ? $clog2(REF_STEPS + 1) : 1;
    localparam logic [W-1:0] MAXV = '1;
    localparam logic [W-1:0] BASE = W'(THR_BASE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t st;
    logic [IN_W-1:0] cur;
    logic [SW-1:0] ch;
    logic [N_CH-1:0] acc;
    logic [W-1:0] u [N_CH];
    logic [W-1:0] thr [N_CH];
    logic [W-1:0] u_c, thr_c, u_l, s, thr_inc, thr_dec, d;
    logic [IN_W:0] i_c;
    logic [SWD-1:0] s_w;
    logic [W:0] t_up;
    logic refr, fire;
`ifdef ALIF_REFRACTORY_EN
    logic [RW-1:0] rc [N_CH];
    assign refr = rc[ch] != '0;
`else
    logic [RW-1:0] unused_ref;
    assign unused_ref = RW'(REF_STEPS);
    assign refr = 1'b0;
`endif

    always_comb begin
        u_c = u[ch];
        thr_c = thr[ch];
        i_c = {1'b0, cur} + (IN_W+1)'(ch) + (IN_W+1)'(1);
        u_l = u_c - (u_c >> LEAK_SHIFT);
        s_w = SWD'(u_l) + SWD'(i_c);
        s = s_w > SWD'(MAXV) ? MAXV : s_w[W-1:0];
        t_up = {1'b0, thr_c} + (W+1)'(THR_INC);
        thr_inc = t_up > {1'b0, MAXV} ? MAXV : t_up[W-1:0];
        // relax toward the resting threshold by at least one per step
        d = (thr_c - BASE) >> THR_DECAY_SHIFT;
        thr_dec = thr_c > BASE ? thr_c - (d == '0 ? W'(1) : d) : thr_c;
        fire = !refr && s >= thr_c;
    end

    assign step_ready = st == IDLE;
    assign mon_state = {1'b0, mon_sel} < (SW+1)'(N_CH) ? u[mon_sel] : '0;
    assign mon_thr = {1'b0, mon_sel} < (SW+1)'(N_CH) ? thr[mon_sel] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            cur <= '0;
            ch <= '0;
            acc <= '0;
            spikes <= '0;
            done <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                u[i] <= '0;
                thr[i] <= BASE;
`ifdef ALIF_REFRACTORY_EN
                rc[i] <= '0;
`endif
            end
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: if (step_valid) begin
                    cur <= current;
                    ch <= '0;
                    acc <= '0;
                    st <= RUN;
                end
                RUN: begin
                    u[ch] <= fire || refr ? '0 : s;
                    thr[ch] <= fire ? thr_inc : thr_dec;
`ifdef ALIF_REFRACTORY_EN
                    rc[ch] <= fire ? RW'(REF_STEPS) : refr ? rc[ch] - RW'(1) : '0;
`endif
                    acc <= acc | (N_CH'(fire) << ch);
                    if (ch == SW'(N_CH - 1)) begin
                        spikes <= acc | (N_CH'(fire) << ch);
                        done <= 1'b1;
                        st <= DONE;
                    end else begin
                        ch <= ch + SW'(1);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alif_array.md
# alif_array

Parametrised array of adaptive leaky integrate-and-fire (ALIF) neurons sharing one time-multiplexed update datapath. Each accepted step processes every channel once: leak, integrate, compare against that channel's adaptive threshold, and optionally enforce a refractory period. The block sits between the tile's input-current bus and the spike output pins, and supersedes fixed three-instance LIF wiring.

## Interface
- N_CH, 3: number of neuron channels (≥1)
- W, 8: membrane and threshold width
- IN_W, 12: input current width
- LEAK_SHIFT, 1: leak per step is u>>LEAK_SHIFT
- THR_BASE, 200: resting threshold (W bits)
- THR_INC, 16: threshold increment per spike
- THR_DECAY_SHIFT, 3: threshold relaxation shift toward THR_BASE
- REF_STEPS, 2: refractory steps after a spike (ALIF_REFRACTORY_EN only)
- One clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- step_valid  in  1  request one network step
- step_ready  out  1  high only in IDLE
- current  in  IN_W  shared input current, latched on accept
- spikes  out  N_CH  spike vector of the last completed step
- done  out  1  one-cycle pulse when spikes updates
- mon_sel  in  clog2(N_CH) (min 1)  monitor channel select
- mon_state  out  W  membrane of channel mon_sel
- mon_thr  out  W  threshold of channel mon_sel

## Operation
- FSM IDLE → RUN → DONE → IDLE. step_valid && step_ready in IDLE latches current, sets ch=0, enters RUN. step_valid outside IDLE is ignored, not queued.
- RUN: one channel per cycle, ch = 0..N_CH-1; after channel N_CH-1 → DONE, spikes loaded with all per-channel spike bits. DONE: done=1 for one cycle, then IDLE.
- Per channel: I = current + ch + 1 (IN_W+1 bits, per-channel offset). u_l = u − (u>>LEAK_SHIFT). s = u_l + I, saturated to 2^W−1.
- Refractory (ref>0): u←0, ref−1, spike 0, threshold decays.
- Else if s ≥ thr: spike 1, u←0, thr←min(thr+THR_INC, 2^W−1), ref←REF_STEPS.
- Else: spike 0, u←s, threshold decays.
- Decay: if thr>THR_BASE, d=(thr−THR_BASE)>>THR_DECAY_SHIFT; thr←thr−max(d,1). thr never drops below THR_BASE.
- Monitor outputs are combinational reads of the state registers; mon_sel ≥ N_CH reads 0.

## Timing
- Reset values: u=0, thr=THR_BASE, ref=0 for all channels; spikes=0; done=0; FSM IDLE (step_ready=1 during and after reset).
- Accept at edge T; channel k written at edge T+1+k; spikes and done valid in cycle after edge T+N_CH; step_ready returns after edge T+N_CH+1. Minimum step period N_CH+2 cycles.
- step_ready low exactly N_CH+1 cycles per step.
- rst mid-step: abandon step, all channels (including already-updated ones) return to reset values, no done pulse.
- spikes holds between steps; unchanged by rejected step_valid.

## Configuration
- ALIF_REFRACTORY_EN defined: per-channel ref counters present, behaviour as above.
- Undefined: no ref storage, REF_STEPS ignored; a channel integrates normally on the step after it spikes (starting from u=0).

## Test plan
- Reset: rst high 3 cycles → spikes=0, done=0, step_ready=1, mon_state=0, mon_thr=200 for sel 0..2, sel 3 reads 0.
- Step current=10 → mon_state ch0/1/2 = 11/12/13, spikes=000, done single pulse in cycle after edge T+3, step_ready low 4 cycles; step_valid held during RUN does not start a second step.
- Leak: after previous, three steps current=0 → ch0 mon_state 7, 5, 4.
- Spike/adapt (refractory on): fresh, current=250 → spikes=111, mon_state=0, mon_thr=216; next two steps spikes=000, thr 214 then 213, u=0; third step spikes=111, thr=229. Refractory off: second step ch0 u=251≥214 → spike.
- Saturation: THR_BASE=250, current=4095 → s clamps 255, spike, mon_thr=255 (clamped, not 266).
- Reset mid-step: rst pulsed two cycles after accept of current=250 → no done, all u=0, thr=200; next step behaves as from fresh.
